stopwatch_lap_ctrl: RTL
=======================

Name: stopwatch_lap_ctrl

Overview:
Single-clock stopwatch controller. It contains its own 10 ms tick prescaler, a min/sec/centisecond counter, a four-state run/split state machine and a first-word-fall-through (FWFT) lap FIFO. It replaces the derived-clock stopwatch commander: everything runs on one clock using clock enables, and lap times are buffered instead of shown once. It drives the display mux and the lap readout path.

Parameters:
TICK_DIV, 500000, clk cycles per 10 ms tick (>=2; the bench uses 4)
LAP_DEPTH, 4, lap FIFO entries (power of two, >=2)
MIN_MAX, 60, minute modulus; minutes count 0..MIN_MAX-1 (<=64)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
pause  in  1  start/stop button; synchronous and debounced upstream; level input, rising edge acts
record  in  1  lap/clear button; same conditioning as pause
lap_rd  in  1  pop the FIFO head when lap_valid_o=1
min_o  out  6  displayed minutes
sec_o  out  6  displayed seconds
ms_10_o  out  7  displayed centiseconds
running_o  out  1  1 in RUN or SPLIT
frozen_o  out  1  1 in SPLIT or HOLD
wrap_o  out  1  1-cycle pulse when the count wraps from (MIN_MAX-1):59:99 to 0:00:00
lap_min_o  out  6  FIFO head minutes
lap_sec_o  out  6  FIFO head seconds
lap_ms_10_o  out  7  FIFO head centiseconds
lap_valid_o  out  1  FIFO not empty
lap_count_o  out  $clog2(LAP_DEPTH+1)  number of entries in the FIFO
lap_ovf_o  out  1  sticky: a push was dropped because the FIFO was full

Behaviour:
- Reset (rst=0, async): state IDLE, prescaler=0, count 0:00:00, FIFO empty, all outputs 0, edge-detect registers 0.
- Edge detect: p_e = pause & ~pause_q; r_e = record & ~record_q. The state changes at the clock edge ending the cycle in which p_e or r_e is true. The effect is visible the next cycle.
- If p_e and r_e are true in the same cycle, both are ignored.
- States:
  - IDLE: stopped, live display.
  - RUN: counting, live display.
  - SPLIT: counting, display frozen.
  - HOLD: stopped, display frozen.
- Transitions on p_e: IDLE->RUN, RUN->IDLE, SPLIT->HOLD, HOLD->SPLIT.
- Transitions on r_e:
  - RUN->SPLIT: capture the current count into the freeze register and push it to the FIFO.
  - SPLIT->RUN: push the current count; display goes live.
  - HOLD->IDLE: display goes live; no push.
  - IDLE->IDLE: clear. Count=0, prescaler=0, FIFO flushed, lap_ovf_o=0.
- Captured and pushed values are the count held in that cycle, before any tick in the same cycle is applied.
- Prescaler: advances only when running_o=1. It retains its value while stopped. It wraps at TICK_DIV-1 and produces a one-cycle tick at the wrap.
- Count on tick: ms_10 0..99; its carry increments sec 0..59; its carry increments min 0..MIN_MAX-1. On wrap to 0:00:00, wrap_o pulses in the same cycle the count shows 0.
- Display: frozen_o=0 gives the live count; frozen_o=1 gives the freeze register.
- FIFO push:
  - When full: the push is dropped, lap_ovf_o is set, contents are unchanged.
  - Simultaneous push and lap_rd when full: both are performed; count stays at LAP_DEPTH; no overflow.
- FIFO pop:
  - lap_rd while empty is ignored.
  - Pop and push on an empty FIFO: the push is performed and the pop is ignored.
  - lap_* outputs show the head combinationally from storage (FWFT). When empty they are held at 0.
- Clear and lap_rd in the same cycle: clear wins.
- Reset mid-count or mid-FIFO: immediate return to reset values.
- Buttons held high: a single action only. A new action needs a low-then-high transition.

Test Plan (TICK_DIV=4, LAP_DEPTH=4, MIN_MAX=60):
- Reset, then pulse pause for 1 cycle, then wait 400 clks -> running_o=1, display 0:01:00; pulse pause again -> running_o=0 and the display holds 0:01:00 for the following 100 clks.
- RUN, record at count 0:00:37 -> frozen_o=1, display 0:00:37 while the live count advances; lap_count_o=1; lap_*=0:00:37. Record again at 0:00:80 -> display live; lap_count_o=2.
- 5 record edges while running -> lap_count_o=4, lap_ovf_o=1, head = first lap. 4× lap_rd -> laps emerge in push order, then lap_valid_o=0 and lap_* read 0.
- Preload count 59:59:98 via a long run (or force), then 8 clks -> wrap_o pulses once and the count reads 0:00:00.
- Pause and record rising in the same cycle from RUN -> no state change and no push. Record from IDLE with laps stored -> count 0, FIFO empty, lap_ovf_o=0.
- Assert rst=0 asynchronously mid-count with 2 laps stored -> all outputs 0 before the next clk edge; after release the state is IDLE.

Source files
------------

// File: rtl/stopwatch_lap_ctrl.sv
// Single-clock stopwatch: 10 ms prescaler, min:sec:cs counter, run/split FSM and FWFT lap FIFO.
// state | meaning: IDLE stopped, live | RUN counting, live | SPLIT counting, frozen | HOLD stopped, frozen
module stopwatch_lap_ctrl #(
  parameter int TICK_DIV  = 500000,
  parameter int LAP_DEPTH = 4,
  parameter int MIN_MAX   = 60
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             pause,
  input  logic                             record,
  input  logic                             lap_rd,
  output logic [5:0]                       min_o,
  output logic [5:0]                       sec_o,
  output logic [6:0]                       ms_10_o,
  output logic                             running_o,
  output logic                             frozen_o,
  output logic                             wrap_o,
  output logic [5:0]                       lap_min_o,
  output logic [5:0]                       lap_sec_o,
  output logic [6:0]                       lap_ms_10_o,
  output logic                             lap_valid_o,
  output logic [$clog2(LAP_DEPTH+1)-1:0]   lap_count_o,
  output logic                             lap_ovf_o
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int AW = $clog2(LAP_DEPTH);
  localparam int CW = $clog2(LAP_DEPTH + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [5:0]    MIN_LAST   = 6'(MIN_MAX - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_SPLIT, S_HOLD} state_t;
  typedef logic [18:0] stamp_t;

  state_t          state_q, state_d;
  logic            pause_q, record_q;
  logic [PW-1:0]   presc_q, presc_d;
  logic [5:0]      min_q, min_d, sec_q, sec_d;
  logic [6:0]      ms_q, ms_d;
  stamp_t          frz_q, frz_d;
  logic            wrap_q, wrap_d, ovf_q, ovf_d;
  logic            running_q, running_d, frozen_q, frozen_d;
  stamp_t          mem_q [LAP_DEPTH];
  stamp_t          mem_d [LAP_DEPTH];
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic   p_e, r_e, p_act, r_act, tick, push, clear, pop, full, do_push;
  stamp_t cur, head;

  always_comb begin
    p_e      = pause & ~pause_q;
    r_e      = record & ~record_q;
    p_act    = p_e & ~r_e;
    r_act    = r_e & ~p_e;
    cur      = {min_q, sec_q, ms_q};
    tick     = running_q && (presc_q == PRESC_LAST);
    state_d  = state_q;
    presc_d  = presc_q;
    min_d    = min_q;
    sec_d    = sec_q;
    ms_d     = ms_q;
    frz_d    = frz_q;
    wrap_d   = 1'b0;
    ovf_d    = ovf_q;
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    push     = 1'b0;
    clear    = 1'b0;

    if (running_q) presc_d = tick ? '0 : presc_q + PW'(1);
    if (tick) begin
      if (ms_q != 7'd99) ms_d = ms_q + 7'd1;
      else begin
        ms_d = '0;
        if (sec_q != 6'd59) sec_d = sec_q + 6'd1;
        else begin
          sec_d = '0;
          if (min_q != MIN_LAST) min_d = min_q + 6'd1;
          else begin
            min_d  = '0;
            wrap_d = 1'b1;
          end
        end
      end
    end

    unique case (state_q)
      S_IDLE:  if (p_act) state_d = S_RUN;
               else if (r_act) clear = 1'b1;
      S_RUN:   if (p_act) state_d = S_IDLE;
               else if (r_act) begin
                 state_d = S_SPLIT;
                 frz_d   = cur;
                 push    = 1'b1;
               end
      S_SPLIT: if (p_act) state_d = S_HOLD;
               else if (r_act) begin
                 state_d = S_RUN;
                 push    = 1'b1;
               end
      S_HOLD:  if (p_act) state_d = S_SPLIT;
               else if (r_act) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A pop frees the slot a same-cycle push needs, so full+pop+push is not an overflow
    pop     = lap_rd && (cnt_q != '0);
    full    = (cnt_q == CW'(LAP_DEPTH));
    do_push = push && (!full || pop);
    if (push && full && !pop) ovf_d = 1'b1;
    if (do_push) begin
      mem_d[wr_ptr_q] = cur;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    cnt_d = cnt_q + CW'(do_push) - CW'(pop);

    if (clear) begin
      presc_d  = '0;
      min_d    = '0;
      sec_d    = '0;
      ms_d     = '0;
      wrap_d   = 1'b0;
      ovf_d    = 1'b0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end

    running_d = (state_d == S_RUN) || (state_d == S_SPLIT);
    frozen_d  = (state_d == S_SPLIT) || (state_d == S_HOLD);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      pause_q   <= 1'b0;
      record_q  <= 1'b0;
      presc_q   <= '0;
      min_q     <= '0;
      sec_q     <= '0;
      ms_q      <= '0;
      frz_q     <= '0;
      wrap_q    <= 1'b0;
      ovf_q     <= 1'b0;
      running_q <= 1'b0;
      frozen_q  <= 1'b0;
      mem_q     <= '{default: '0};
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pause_q   <= pause;
      record_q  <= record;
      presc_q   <= presc_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      ms_q      <= ms_d;
      frz_q     <= frz_d;
      wrap_q    <= wrap_d;
      ovf_q     <= ovf_d;
      running_q <= running_d;
      frozen_q  <= frozen_d;
      mem_q     <= mem_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign head = lap_valid_o ? mem_q[rd_ptr_q] : '0;

  assign min_o       = frozen_q ? frz_q[18:13] : min_q;
  assign sec_o       = frozen_q ? frz_q[12:7]  : sec_q;
  assign ms_10_o     = frozen_q ? frz_q[6:0]   : ms_q;
  assign running_o   = running_q;
  assign frozen_o    = frozen_q;
  assign wrap_o      = wrap_q;
  assign lap_valid_o = (cnt_q != '0);
  assign lap_min_o   = head[18:13];
  assign lap_sec_o   = head[12:7];
  assign lap_ms_10_o = head[6:0];
  assign lap_count_o = cnt_q;
  assign lap_ovf_o   = ovf_q;

endmodule
